// File: rtl/mul_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller:
// FSM state encoding, partial-product shift amounts and the helpers
// used to pick the next partial-product state.
package mul_pkg;

   // IDLE/DONE bracket the four partial-product states; PPn = n+1.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PP0  = 3'd1,
      PP1  = 3'd2,
      PP2  = 3'd3,
      PP3  = 3'd4,
      DONE = 3'd5
   } state_t;

   // Left shift applied to each 8-bit partial product before accumulation.
   localparam int PP_SHIFT0 = 0;
   localparam int PP_SHIFT1 = 4;
   localparam int PP_SHIFT2 = 4;
   localparam int PP_SHIFT3 = 8;

   // Bit n is set when partial product n has two non-zero nibbles,
   // i.e. when it can contribute something to the product.
   function automatic logic [3:0] pp_live_mask(input logic [7:0] a, input logic [7:0] b);
      logic [3:0] m;
      m[0] = (a[3:0] != 4'd0) && (b[3:0] != 4'd0);
      m[1] = (a[7:4] != 4'd0) && (b[3:0] != 4'd0);
      m[2] = (a[3:0] != 4'd0) && (b[7:4] != 4'd0);
      m[3] = (a[7:4] != 4'd0) && (b[7:4] != 4'd0);
      return m;
   endfunction

   // First partial-product state at or after index 'from' whose live bit
   // is set; DONE when none remain.
   function automatic state_t first_live_pp(input logic [3:0] live, input int from);
      state_t r;
      r = DONE;
      for (int i = 3; i >= 0; i--) begin
         if (i >= from && live[i]) begin
            r = state_t'(3'(i + 1));
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/multiplier.sv
// 4x4 unsigned array multiplier: one shifted row of 'a' per bit of 'b',
// rows summed combinationally into an 8-bit product.
module multiplier (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [7:0] p
);

   logic [7:0] row [4];

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_row
         assign row[gi] = b[gi] ? ({4'd0, a} << gi) : 8'd0;
      end
   endgenerate

   assign p = row[0] + row[1] + row[2] + row[3];

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier built around a single shared 4x4
// multiplier. Operands are split into nibbles and the four partial
// products are accumulated over successive cycles.
// Build option: define MUL8_SEQ_SKIP_ZERO_EN to skip partial products
// whose nibble pair contains a zero nibble (variable latency).
module mul8_seq_ctrl
   import mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] p,
   output logic        busy
);

   state_t      state_reg, state_next;
   logic [7:0]  a_reg, a_next;
   logic [7:0]  b_reg, b_next;
   logic [15:0] acc_reg, acc_next;

   logic [3:0]  nib_a, nib_b;
   logic [3:0]  shift;
   logic [7:0]  pp;
   logic [15:0] pp_shifted;
   logic [3:0]  live_in, live_reg;

`ifdef MUL8_SEQ_SKIP_ZERO_EN
   // Incoming operands decide the first state; latched ones decide the rest.
   assign live_in  = pp_live_mask(a, b);
   assign live_reg = pp_live_mask(a_reg, b_reg);
`else
   assign live_in  = 4'hF;
   assign live_reg = 4'hF;
`endif

   // Pick the nibble pair and shift amount for the current partial product.
   always_comb begin
      nib_a = a_reg[3:0];
      nib_b = b_reg[3:0];
      shift = 4'(PP_SHIFT0);
      case (state_reg)
         PP1: begin
            nib_a = a_reg[7:4];
            shift = 4'(PP_SHIFT1);
         end
         PP2: begin
            nib_b = b_reg[7:4];
            shift = 4'(PP_SHIFT2);
         end
         PP3: begin
            nib_a = a_reg[7:4];
            nib_b = b_reg[7:4];
            shift = 4'(PP_SHIFT3);
         end
         default: ;
      endcase
   end

   multiplier u_mul (
      .a (nib_a),
      .b (nib_b),
      .p (pp)
   );

   assign pp_shifted = {8'd0, pp} << shift;

   // Next-state, operand capture and accumulation.
   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      acc_next   = acc_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               a_next     = a;
               b_next     = b;
               acc_next   = 16'd0;
               state_next = first_live_pp(live_in, 0);
            end
         end
         PP0: begin
            acc_next   = acc_reg + pp_shifted;
            state_next = first_live_pp(live_reg, 1);
         end
         PP1: begin
            acc_next   = acc_reg + pp_shifted;
            state_next = first_live_pp(live_reg, 2);
         end
         PP2: begin
            acc_next   = acc_reg + pp_shifted;
            state_next = first_live_pp(live_reg, 3);
         end
         PP3: begin
            acc_next   = acc_reg + pp_shifted;
            state_next = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State and datapath registers; reset drops any operation in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         a_reg     <= 8'd0;
         b_reg     <= 8'd0;
         acc_reg   <= 16'd0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         acc_reg   <= acc_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg == PP0) || (state_reg == PP1) ||
                      (state_reg == PP2) || (state_reg == PP3);
   assign p         = out_valid ? acc_reg : 16'd0;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench for mul8_seq_ctrl: directed corner cases plus
// randomized operations checked against an arithmetic reference model.
module tb_mul8_seq_ctrl;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] p;
   logic        busy;

   int errors;
   int checks;

   mul8_seq_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Edges after the accepting edge until DONE is reached.
   function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y);
`ifdef MUL8_SEQ_SKIP_ZERO_EN
      int n;
      n = 0;
      if (x[3:0] != 0 && y[3:0] != 0) n++;
      if (x[7:4] != 0 && y[3:0] != 0) n++;
      if (x[3:0] != 0 && y[7:4] != 0) n++;
      if (x[7:4] != 0 && y[7:4] != 0) n++;
      return n;
`else
      return 4;
`endif
   endfunction

   // One full transaction, entered and left at a falling edge.
   task automatic do_op(input logic [7:0] x, input logic [7:0] y,
                        input int hold, input bit junk);
      logic [15:0] exp_p;
      int          k;
      exp_p = 16'(int'(x) * int'(y));
      check("ready_before", in_ready, 1);
      in_valid  = 1'b1;
      a         = x;
      b         = y;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (out_valid !== 1'b1 && k < 20) begin
         check("busy_pp", busy, 1);
         check("p_zero_pp", p, 0);
         check("ready_pp", in_ready, 0);
         if (junk && k == 1) begin
            in_valid = 1'b1;
            a        = 8'h55;
            b        = 8'h02;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         k++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("latency", k, exp_lat(x, y));
      check("product", p, exp_p);
      check("busy_done", busy, 0);
      check("ready_done", in_ready, 0);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_valid", out_valid, 1);
         check("hold_p", p, exp_p);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_after", out_valid, 0);
      check("ready_after", in_ready, 1);
      check("p_after", p, 0);
      $display("op a=0x%02h b=0x%02h p=0x%04h lat=%0d hold=%0d", x, y, exp_p, k, hold);
   endtask

   initial begin
      logic [7:0] ra, rb;
      errors    = 0;
      checks    = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = 8'd0;
      b         = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_ready", in_ready, 1);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_p", p, 0);
      rst_n = 1'b1;

      do_op(8'hFF, 8'hFF, 0, 1'b0);
      do_op(8'h12, 8'h34, 3, 1'b0);
      do_op(8'h12, 8'h34, 0, 1'b1);
      do_op(8'h10, 8'h03, 1, 1'b0);
      do_op(8'h00, 8'h7F, 0, 1'b0);

      // Abort an operation with reset while the third partial product runs.
      in_valid = 1'b1;
      a        = 8'h12;
      b        = 8'h34;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_valid", out_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_ready", in_ready, 1);
      check("abort_p", p, 0);
      $display("op a=0x12 b=0x34 aborted by reset");
      do_op(8'hA7, 8'h3C, 0, 1'b0);

      for (int i = 0; i < 30; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         if ($urandom_range(0, 3) == 0) ra[3:0] = 4'd0;
         if ($urandom_range(0, 3) == 0) rb[7:4] = 4'd0;
         do_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
